// File: rtl/action_fsm_multi.sv
// action_fsm_multi: per-player fencing action FSM, stepped once per frame.
// Frame inputs are captured at t, the FSM steps at t+1 and registered outputs land with data_valid_out at t+2.
module action_fsm_multi #(
   parameter int X_W            = 11,
   parameter int Y_W            = 10,
   parameter int HEALTH_W       = 3,
   parameter int MAX_HEALTH     = 5,
   parameter int BLOCK_FRAMES   = 240,
   parameter int ATTACK_FRAMES  = 30,
   parameter int RECOVER_FRAMES = 60,
   parameter int PARRY_FRAMES   = 90,
   parameter int CNT_W          = 10
) (
   input  logic                clk_pixel_in,
   input  logic                rst_n_in,
   input  logic                game_reset_in,
   input  logic                ir_valid_in,
   input  logic                block_in,
   input  logic                lunge_in,
   input  logic                release_in,
   input  logic                frame_valid_in,
   input  logic [X_W-1:0]      saber_x_in,
   input  logic [Y_W-1:0]      saber_y_in,
   input  logic [1:0]          opp_state_in,
   input  logic                opp_scored_in,
   input  logic                attack_hit_in,
   input  logic                collide_in,
   output logic [1:0]          saber_state_out,
   output logic [X_W-1:0]      attack_x_out,
   output logic [Y_W-1:0]      attack_y_out,
   output logic [HEALTH_W-1:0] health_out,
   output logic                scored_out,
   output logic                game_over_out,
   output logic                data_valid_out,
   output logic [2:0]          state_dbg_out
);

   typedef enum logic [2:0] {
      S_REST    = 3'd0,
      S_BLOCK   = 3'd1,
      S_ATTACK  = 3'd2,
      S_SCORE   = 3'd3,
      S_RECOVER = 3'd4,
      S_PARRIED = 3'd5,
      S_DEAD    = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0]    BLOCK_LAST   = CNT_W'(BLOCK_FRAMES - 1);
   localparam logic [CNT_W-1:0]    ATTACK_LAST  = CNT_W'(ATTACK_FRAMES - 1);
   localparam logic [CNT_W-1:0]    RECOVER_LAST = CNT_W'(RECOVER_FRAMES - 1);
   localparam logic [CNT_W-1:0]    PARRY_LAST   = CNT_W'(PARRY_FRAMES - 1);
   localparam logic [HEALTH_W-1:0] HEALTH_MAX   = HEALTH_W'(MAX_HEALTH);
   localparam logic [HEALTH_W-1:0] HEALTH_ONE   = HEALTH_W'(1);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [HEALTH_W-1:0]   health_q, health_d;
   logic                  blk_q, blk_d, lng_q, lng_d, rel_q, rel_d;
   logic [X_W-1:0]        atk_x_q, atk_x_d;
   logic [Y_W-1:0]        atk_y_q, atk_y_d;
   logic                  score_q, score_d;
   logic                  p1_q, p2_q;
   logic [X_W-1:0]        cap_x_q;
   logic [Y_W-1:0]        cap_y_q;
   logic [1:0]            cap_opp_q;
   logic                  cap_opp_sc_q, cap_hit_q, cap_col_q;
   logic                  frame_start;
   logic                  timed;

   // frame_valid_in is a one-cycle strobe with no back-pressure; strobes arriving while
   // a frame occupies the t+1/t+2 slots are dropped, never queued.
   assign frame_start   = frame_valid_in && !p1_q && !p2_q;
   assign state_dbg_out = state_q;
   assign timed = (state_d == S_BLOCK) || (state_d == S_ATTACK) ||
                  (state_d == S_RECOVER) || (state_d == S_PARRIED);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      health_d = health_q;
      atk_x_d  = atk_x_q;
      atk_y_d  = atk_y_q;
      score_d  = score_q;
      blk_d    = blk_q;
      lng_d    = lng_q;
      rel_d    = rel_q;
      if (p1_q) begin
         score_d = 1'b0;
         case (state_q)
            S_REST: begin
               if (blk_q) begin
                  state_d = S_BLOCK;
               end else if (lng_q) begin
                  state_d = S_ATTACK;
                  atk_x_d = cap_x_q;
                  atk_y_d = cap_y_q;
               end
            end
            S_BLOCK: if (rel_q || lng_q || cnt_q == BLOCK_LAST) state_d = S_REST;
            S_ATTACK: begin
               if (rel_q && cap_hit_q) begin
                  state_d = S_SCORE;
                  score_d = 1'b1;
               end else if (cap_col_q && cap_opp_q == 2'b10) begin
                  state_d = S_PARRIED;
               end else if (cap_col_q || rel_q || blk_q || cnt_q == ATTACK_LAST) begin
                  state_d = S_RECOVER;
               end
            end
            S_SCORE:   state_d = S_RECOVER;
            S_RECOVER: if (cnt_q == RECOVER_LAST) state_d = S_REST;
            S_PARRIED: if (cnt_q == PARRY_LAST) state_d = S_REST;
            default:   state_d = S_DEAD;
         endcase
         // The last point of health overrides whatever the action logic chose.
         if (state_q != S_DEAD && cap_opp_sc_q && health_q != '0) begin
            health_d = health_q - HEALTH_ONE;
            if (health_q == HEALTH_ONE) state_d = S_DEAD;
         end
         if (state_d != state_q) cnt_d = '0;
         else if (timed)         cnt_d = cnt_q + CNT_W'(1);
         if (state_q == S_BLOCK && state_d != S_BLOCK)   blk_d = 1'b0;
         if (state_q == S_ATTACK && state_d != S_ATTACK) lng_d = 1'b0;
      end
      if (ir_valid_in) begin
         blk_d = block_in;
         lng_d = lunge_in;
         rel_d = release_in;
      end
   end

   always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q         <= S_REST;
         cnt_q           <= '0;
         health_q        <= HEALTH_MAX;
         {blk_q, lng_q, rel_q} <= 3'b000;
         atk_x_q         <= '0;
         atk_y_q         <= '0;
         score_q         <= 1'b0;
         p1_q            <= 1'b0;
         p2_q            <= 1'b0;
         cap_x_q         <= '0;
         cap_y_q         <= '0;
         cap_opp_q       <= 2'b00;
         {cap_opp_sc_q, cap_hit_q, cap_col_q} <= 3'b000;
         saber_state_out <= 2'b00;
         attack_x_out    <= '0;
         attack_y_out    <= '0;
         health_out      <= HEALTH_MAX;
         scored_out      <= 1'b0;
         game_over_out   <= 1'b0;
         data_valid_out  <= 1'b0;
      end else if (game_reset_in) begin
         state_q         <= S_REST;
         cnt_q           <= '0;
         health_q        <= HEALTH_MAX;
         {blk_q, lng_q, rel_q} <= 3'b000;
         atk_x_q         <= '0;
         atk_y_q         <= '0;
         score_q         <= 1'b0;
         p1_q            <= 1'b0;
         p2_q            <= 1'b0;
         saber_state_out <= 2'b00;
         attack_x_out    <= '0;
         attack_y_out    <= '0;
         health_out      <= HEALTH_MAX;
         scored_out      <= 1'b0;
         game_over_out   <= 1'b0;
         data_valid_out  <= 1'b0;
      end else begin
         if (frame_start) begin
            cap_x_q      <= saber_x_in;
            cap_y_q      <= saber_y_in;
            cap_opp_q    <= opp_state_in;
            cap_opp_sc_q <= opp_scored_in;
            cap_hit_q    <= attack_hit_in;
            cap_col_q    <= collide_in;
         end
         p1_q     <= frame_start;
         p2_q     <= p1_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         health_q <= health_d;
         blk_q    <= blk_d;
         lng_q    <= lng_d;
         rel_q    <= rel_d;
         atk_x_q  <= atk_x_d;
         atk_y_q  <= atk_y_d;
         score_q  <= score_d;
         data_valid_out <= p2_q;
         if (p2_q) begin
            case (state_q)
               S_REST:   saber_state_out <= 2'b00;
               S_ATTACK: saber_state_out <= 2'b01;
               S_BLOCK:  saber_state_out <= 2'b10;
               default:  saber_state_out <= 2'b11;
            endcase
            attack_x_out  <= (state_q == S_ATTACK || state_q == S_SCORE) ? atk_x_q : '0;
            attack_y_out  <= (state_q == S_ATTACK || state_q == S_SCORE) ? atk_y_q : '0;
            health_out    <= health_q;
            scored_out    <= score_q;
            game_over_out <= (state_q == S_DEAD);
         end
      end
   end

endmodule

// File: tb/tb_action_fsm_multi.sv
// Directed bench for action_fsm_multi: hand-computed frame-by-frame expectations with default parameters.
module tb_action_fsm_multi;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        game_reset = 1'b0;
   logic        ir_valid = 1'b0;
   logic        blk = 1'b0, lng = 1'b0, rel = 1'b0;
   logic        fv = 1'b0;
   logic [10:0] sx = '0;
   logic [9:0]  sy = '0;
   logic [1:0]  opp = '0;
   logic        opp_sc = 1'b0, hit = 1'b0, col = 1'b0;
   logic [1:0]  st;
   logic [10:0] ax;
   logic [9:0]  ay;
   logic [2:0]  hl;
   logic        sc, go, dv;
   logic [2:0]  dbg;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   action_fsm_multi dut (
      .clk_pixel_in(clk), .rst_n_in(rst_n), .game_reset_in(game_reset),
      .ir_valid_in(ir_valid), .block_in(blk), .lunge_in(lng), .release_in(rel),
      .frame_valid_in(fv), .saber_x_in(sx), .saber_y_in(sy), .opp_state_in(opp),
      .opp_scored_in(opp_sc), .attack_hit_in(hit), .collide_in(col),
      .saber_state_out(st), .attack_x_out(ax), .attack_y_out(ay), .health_out(hl),
      .scored_out(sc), .game_over_out(go), .data_valid_out(dv), .state_dbg_out(dbg)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic press(input logic b, input logic l, input logic r);
      @(negedge clk);
      ir_valid = 1'b1; blk = b; lng = l; rel = r;
      @(negedge clk);
      ir_valid = 1'b0; blk = 1'b0; lng = 1'b0; rel = 1'b0;
   endtask

   // Launches one frame and returns at the negedge where data_valid_out must be high.
   task automatic do_frame(input string tag, input logic [10:0] x, input logic [9:0] y,
                           input logic [1:0] o, input logic os, input logic h, input logic c,
                           input logic [1:0] e_st, input logic [2:0] e_h);
      @(negedge clk);
      sx = x; sy = y; opp = o; opp_sc = os; hit = h; col = c; fv = 1'b1;
      @(negedge clk);
      fv = 1'b0; opp_sc = 1'b0; hit = 1'b0; col = 1'b0; opp = 2'b00;
      check_eq({tag, "_dv_t"}, dv, 1'b0);
      @(negedge clk);
      check_eq({tag, "_dv_t1"}, dv, 1'b0);
      @(negedge clk);
      check_eq({tag, "_dv_t2"}, dv, 1'b1);
      check_eq({tag, "_state"}, st, e_st);
      check_eq({tag, "_health"}, hl, e_h);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      check_eq("rst_state", st, 2'b00);
      check_eq("rst_health", hl, 3'd5);
      check_eq("rst_dv", dv, 1'b0);
      check_eq("rst_go", go, 1'b0);
      rst_n = 1'b1;

      // 1: idle frame
      do_frame("idle", 11'd9, 10'd9, 2'b00, 0, 0, 0, 2'b00, 3'd5);
      check_eq("idle_scored", sc, 1'b0);
      @(negedge clk);
      check_eq("idle_dv_pulse", dv, 1'b0);

      // 2: lunge, then release with hit -> SCORE -> 60 RECOVER frames
      press(0, 1, 0);
      do_frame("atk", 11'd100, 10'd50, 2'b00, 0, 0, 0, 2'b01, 3'd5);
      check_eq("atk_x", ax, 11'd100);
      check_eq("atk_y", ay, 10'd50);
      press(0, 0, 1);
      do_frame("score", 11'd7, 10'd7, 2'b00, 0, 1, 0, 2'b11, 3'd5);
      check_eq("score_sc", sc, 1'b1);
      check_eq("score_x", ax, 11'd100);
      check_eq("score_y", ay, 10'd50);
      check_eq("score_dbg", dbg, 3'd3);
      for (int i = 0; i < 60; i++) begin
         do_frame("recover", 0, 0, 2'b00, 0, 0, 0, 2'b11, 3'd5);
         if (i == 0) begin
            check_eq("recover_sc", sc, 1'b0);
            check_eq("recover_x", ax, 11'd0);
         end
      end
      do_frame("recover_end", 0, 0, 2'b00, 0, 0, 0, 2'b00, 3'd5);

      // 3: attack parried -> 90 frames PARRIED
      press(0, 1, 0);
      do_frame("patk", 11'd300, 10'd200, 2'b00, 0, 0, 0, 2'b01, 3'd5);
      do_frame("parry", 0, 0, 2'b10, 0, 0, 1, 2'b11, 3'd5);
      check_eq("parry_dbg", dbg, 3'd5);
      check_eq("parry_x", ax, 11'd0);
      for (int i = 0; i < 89; i++) do_frame("parried", 0, 0, 2'b00, 0, 0, 0, 2'b11, 3'd5);
      do_frame("parry_end", 0, 0, 2'b00, 0, 0, 0, 2'b00, 3'd5);
      do_frame("parry_noreatk", 0, 0, 2'b00, 0, 0, 0, 2'b00, 3'd5);

      // 4: block held to timeout, flag cleared
      press(1, 0, 0);
      do_frame("blk", 0, 0, 2'b00, 0, 0, 0, 2'b10, 3'd5);
      for (int i = 0; i < 239; i++) do_frame("blk_hold", 0, 0, 2'b00, 0, 0, 0, 2'b10, 3'd5);
      do_frame("blk_end", 0, 0, 2'b00, 0, 0, 0, 2'b00, 3'd5);
      do_frame("blk_noreentry", 0, 0, 2'b00, 0, 0, 0, 2'b00, 3'd5);

      // Attack timeout after 30 frames -> RECOVER
      press(0, 1, 0);
      do_frame("tatk", 11'd5, 10'd6, 2'b00, 0, 0, 0, 2'b01, 3'd5);
      for (int i = 0; i < 29; i++) do_frame("tatk_hold", 0, 0, 2'b00, 0, 0, 0, 2'b01, 3'd5);
      do_frame("tatk_to", 0, 0, 2'b00, 0, 0, 0, 2'b11, 3'd5);
      for (int i = 0; i < 59; i++) do_frame("tatk_rec", 0, 0, 2'b00, 0, 0, 0, 2'b11, 3'd5);
      do_frame("tatk_rest", 0, 0, 2'b00, 0, 0, 0, 2'b00, 3'd5);

      // 5: health drain, double touch into DEAD, saturation, game reset
      do_frame("hit1", 0, 0, 2'b00, 1, 0, 0, 2'b00, 3'd4);
      do_frame("hit2", 0, 0, 2'b00, 1, 0, 0, 2'b00, 3'd3);
      do_frame("hit3", 0, 0, 2'b00, 1, 0, 0, 2'b00, 3'd2);
      do_frame("hit4", 0, 0, 2'b00, 1, 0, 0, 2'b00, 3'd1);
      check_eq("hit4_go", go, 1'b0);
      press(0, 1, 0);
      do_frame("datk", 11'd20, 10'd30, 2'b00, 0, 0, 0, 2'b01, 3'd1);
      press(0, 0, 1);
      do_frame("dtouch", 0, 0, 2'b00, 1, 1, 0, 2'b11, 3'd0);
      check_eq("dtouch_sc", sc, 1'b1);
      check_eq("dtouch_go", go, 1'b1);
      check_eq("dtouch_dbg", dbg, 3'd6);
      check_eq("dtouch_x", ax, 11'd0);
      do_frame("hit6", 0, 0, 2'b00, 1, 0, 0, 2'b11, 3'd0);
      check_eq("hit6_sc", sc, 1'b0);
      check_eq("hit6_go", go, 1'b1);
      press(0, 1, 0);
      do_frame("dead_btn", 0, 0, 2'b00, 0, 0, 0, 2'b11, 3'd0);
      @(negedge clk);
      game_reset = 1'b1;
      @(negedge clk);
      game_reset = 1'b0;
      check_eq("grst_health", hl, 3'd5);
      check_eq("grst_state", st, 2'b00);
      check_eq("grst_go", go, 1'b0);
      check_eq("grst_dv", dv, 1'b0);
      check_eq("grst_dbg", dbg, 3'd0);
      do_frame("grst_frame", 0, 0, 2'b00, 0, 0, 0, 2'b00, 3'd5);

      // 6: back-to-back strobes yield one data_valid_out
      press(0, 1, 0);
      @(negedge clk);
      sx = 11'd40; sy = 10'd41; fv = 1'b1;
      @(negedge clk);
      sx = 11'd99; sy = 10'd99;
      @(negedge clk);
      fv = 1'b0;
      check_eq("b2b_dv_t1", dv, 1'b0);
      @(negedge clk);
      check_eq("b2b_dv_t2", dv, 1'b1);
      check_eq("b2b_state", st, 2'b01);
      check_eq("b2b_x", ax, 11'd40);
      @(negedge clk);
      check_eq("b2b_dv_t3", dv, 1'b0);
      @(negedge clk);
      check_eq("b2b_dv_t4", dv, 1'b0);

      // rst_n low while a frame is in flight
      @(negedge clk);
      fv = 1'b1;
      @(negedge clk);
      fv = 1'b0;
      rst_n = 1'b0;
      #1;
      check_eq("arst_state", st, 2'b00);
      check_eq("arst_x", ax, 11'd0);
      check_eq("arst_health", hl, 3'd5);
      check_eq("arst_dv", dv, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("arst_dv_t2", dv, 1'b0);
      @(negedge clk);
      check_eq("arst_dv_t3", dv, 1'b0);
      do_frame("arst_frame", 0, 0, 2'b00, 0, 0, 0, 2'b00, 3'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
